// File: rtl/local_bias_ctrl.sv
// Power sequencing and test-bus arbitration for the local_bias analog block.
// Settle timer is a down-counter; the bus arbiter is live only while bias is ready.
module local_bias_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       sup_ok,
    input  logic [1:0] atb_req,
    input  logic [1:0] atb_sel0,
    input  logic [1:0] atb_sel1,
    output logic       pdb,
    output logic       bias_ready,
    output logic [1:0] atb_ena,
    output logic [1:0] atb_gnt,
    output logic       fault
);

    // state    | meaning
    // S_OFF    | bias powered down, waiting for en with a good supply
    // S_SETTLE | pdb high, settle timer counting down
    // S_READY  | bias settled, test-bus arbiter active
    // S_FAULT  | supply left window; held until en drops
    typedef enum logic [1:0] {S_OFF, S_SETTLE, S_READY, S_FAULT} state_t;

    localparam int CW = $clog2(SETTLE_CYCLES + 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      gnt_q, gnt_d;
    logic [1:0]      ena_q, ena_d;
    logic            gap_q, gap_d;
    logic            ptr_q, ptr_d;
    logic            pdb_q, pdb_d;
    logic            rdy_q, rdy_d;
    logic            flt_q, flt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_OFF;
            cnt_q   <= '0;
            gnt_q   <= 2'b00;
            ena_q   <= 2'b00;
            gap_q   <= 1'b0;
            ptr_q   <= 1'b0;
            pdb_q   <= 1'b0;
            rdy_q   <= 1'b0;
            flt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            ena_q   <= ena_d;
            gap_q   <= gap_d;
            ptr_q   <= ptr_d;
            pdb_q   <= pdb_d;
            rdy_q   <= rdy_d;
            flt_q   <= flt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_OFF: begin
                if (en && sup_ok) begin
                    state_d = S_SETTLE;
                    cnt_d   = CW'(SETTLE_CYCLES - 1);
                end
            end
            S_SETTLE: begin
                if (!sup_ok)              state_d = S_FAULT;
                else if (!en)             state_d = S_OFF;
                else if (cnt_q == '0)     state_d = S_READY;
                else                      cnt_d   = cnt_q - 1'b1;
            end
            S_READY: begin
                if (!sup_ok)              state_d = S_FAULT;
                else if (!en)             state_d = S_OFF;
            end
            S_FAULT: begin
                if (!en)                  state_d = S_OFF;
            end
            default:                      state_d = S_OFF;
        endcase
    end

    // Outputs are registered, so they are decoded from the next state.
    always_comb begin
        pdb_d = (state_d == S_SETTLE) || (state_d == S_READY);
        rdy_d = (state_d == S_READY);
        flt_d = (state_d == S_FAULT);
    end

    // Arbiter: only grants while staying in READY; a released grant costs one
    // empty gap cycle so two test-bus codes are never driven back to back.
    always_comb begin
        gnt_d = gnt_q;
        ena_d = ena_q;
        gap_d = 1'b0;
        ptr_d = ptr_q;
        if ((state_q == S_READY) && (state_d == S_READY)) begin
            if (gnt_q != 2'b00) begin
                if ((gnt_q & atb_req) == 2'b00) begin
                    gnt_d = 2'b00;
                    ena_d = 2'b00;
                    gap_d = 1'b1;
                end
            end else if (!gap_q) begin
                if (atb_req[0] && (!atb_req[1] || !ptr_q)) begin
                    gnt_d = 2'b01;
                    ena_d = atb_sel0;
                    ptr_d = 1'b1;
                end else if (atb_req[1]) begin
                    gnt_d = 2'b10;
                    ena_d = atb_sel1;
                    ptr_d = 1'b0;
                end
            end
        end else begin
            gnt_d = 2'b00;
            ena_d = 2'b00;
        end
    end

    assign pdb        = pdb_q;
    assign bias_ready = rdy_q;
    assign fault      = flt_q;
    assign atb_gnt    = gnt_q;
    assign atb_ena    = ena_q;

endmodule

// File: tb/tb_local_bias_ctrl.sv
// Scenario bench for local_bias_ctrl; expected output vectors
// {pdb, bias_ready, fault, gnt, ena} are queued before each edge.
module tb_local_bias_ctrl;

    logic       clk = 1'b0;
    logic       rst, en, sup_ok;
    logic [1:0] atb_req, atb_sel0, atb_sel1;
    logic       pdb, bias_ready, fault;
    logic [1:0] atb_ena, atb_gnt;

    logic [6:0] exp_q[$];
    logic [6:0] expv, got;
    int         checks = 0;
    int         failures = 0;

    localparam logic [6:0] OFFV = 7'b000_00_00;
    localparam logic [6:0] SETV = 7'b100_00_00;
    localparam logic [6:0] RDYV = 7'b110_00_00;
    localparam logic [6:0] FLTV = 7'b001_00_00;

    local_bias_ctrl #(.SETTLE_CYCLES(8)) dut (
        .clk(clk), .rst(rst), .en(en), .sup_ok(sup_ok),
        .atb_req(atb_req), .atb_sel0(atb_sel0), .atb_sel1(atb_sel1),
        .pdb(pdb), .bias_ready(bias_ready), .atb_ena(atb_ena),
        .atb_gnt(atb_gnt), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        got  = {pdb, bias_ready, fault, atb_gnt, atb_ena};
        expv = exp_q.pop_front();
        checks++;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; sup_ok = 1'b1;
        atb_req = 2'b00; atb_sel0 = 2'b00; atb_sel1 = 2'b00;
        exp_q.push_back(OFFV); tick();
        if (got !== expv) begin failures++; $display("FAIL reset: got %b want %b", got, expv); end
        rst = 1'b0;
    endtask

    task automatic test_powerup();
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(OFFV); tick();
            if (got !== expv) begin failures++; $display("FAIL idle_off[%0d]: got %b want %b", i, got, expv); end
        end
        en = 1'b1;
        for (int j = 0; j < 12; j++) begin
            exp_q.push_back(j >= 8 ? RDYV : SETV); tick();
            if (got !== expv) begin failures++; $display("FAIL powerup[%0d]: got %b want %b", j, got, expv); end
        end
    endtask

    task automatic test_fault_ready();
        sup_ok = 1'b0;
        exp_q.push_back(FLTV); tick();
        if (got !== expv) begin failures++; $display("FAIL fault_set: got %b want %b", got, expv); end
        sup_ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(FLTV); tick();
            if (got !== expv) begin failures++; $display("FAIL fault_sticky[%0d]: got %b want %b", i, got, expv); end
        end
        en = 1'b0;
        exp_q.push_back(OFFV); tick();
        if (got !== expv) begin failures++; $display("FAIL fault_clear: got %b want %b", got, expv); end
        en = 1'b1;
        for (int j = 0; j < 9; j++) begin
            exp_q.push_back(j == 8 ? RDYV : SETV); tick();
            if (got !== expv) begin failures++; $display("FAIL resettle[%0d]: got %b want %b", j, got, expv); end
        end
    endtask

    task automatic test_abort();
        en = 1'b0;
        exp_q.push_back(OFFV); tick();
        if (got !== expv) begin failures++; $display("FAIL abort_pre: got %b want %b", got, expv); end
        en = 1'b1;
        for (int j = 0; j < 3; j++) begin
            exp_q.push_back(SETV); tick();
            if (got !== expv) begin failures++; $display("FAIL abort_settle[%0d]: got %b want %b", j, got, expv); end
        end
        en = 1'b0;
        for (int j = 0; j < 8; j++) begin
            exp_q.push_back(OFFV); tick();
            if (got !== expv) begin failures++; $display("FAIL abort_off[%0d]: got %b want %b", j, got, expv); end
        end
        en = 1'b1;
        for (int j = 0; j < 9; j++) begin
            exp_q.push_back(j == 8 ? RDYV : SETV); tick();
            if (got !== expv) begin failures++; $display("FAIL abort_restart[%0d]: got %b want %b", j, got, expv); end
        end
    endtask

    task automatic test_simultaneous();
        atb_req = 2'b11; atb_sel0 = 2'b01; atb_sel1 = 2'b10;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(7'b110_01_01); tick();
            if (got !== expv) begin failures++; $display("FAIL tie_grant0[%0d]: got %b want %b", i, got, expv); end
        end
        atb_req = 2'b10;
        exp_q.push_back(RDYV); tick();
        if (got !== expv) begin failures++; $display("FAIL release: got %b want %b", got, expv); end
        exp_q.push_back(RDYV); tick();
        if (got !== expv) begin failures++; $display("FAIL gap: got %b want %b", got, expv); end
        exp_q.push_back(7'b110_10_10); tick();
        if (got !== expv) begin failures++; $display("FAIL grant1: got %b want %b", got, expv); end
        atb_sel1 = 2'b11;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(7'b110_10_10); tick();
            if (got !== expv) begin failures++; $display("FAIL latch_sel[%0d]: got %b want %b", i, got, expv); end
        end
    endtask

    task automatic test_gating();
        en = 1'b0;
        exp_q.push_back(OFFV); tick();
        if (got !== expv) begin failures++; $display("FAIL gate_en_drop: got %b want %b", got, expv); end
        atb_req = 2'b11; atb_sel0 = 2'b01; atb_sel1 = 2'b10;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(OFFV); tick();
            if (got !== expv) begin failures++; $display("FAIL gate_off[%0d]: got %b want %b", i, got, expv); end
        end
        en = 1'b1;
        for (int j = 0; j < 9; j++) begin
            exp_q.push_back(j == 8 ? RDYV : SETV); tick();
            if (got !== expv) begin failures++; $display("FAIL gate_settle[%0d]: got %b want %b", j, got, expv); end
        end
        exp_q.push_back(7'b110_01_01); tick();
        if (got !== expv) begin failures++; $display("FAIL gate_tie: got %b want %b", got, expv); end
        sup_ok = 1'b0;
        exp_q.push_back(FLTV); tick();
        if (got !== expv) begin failures++; $display("FAIL gate_fault: got %b want %b", got, expv); end
        en = 1'b0; sup_ok = 1'b1;
        exp_q.push_back(OFFV); tick();
        if (got !== expv) begin failures++; $display("FAIL gate_recover: got %b want %b", got, expv); end
    endtask

    task automatic test_reset_mid();
        en = 1'b1; atb_req = 2'b10; atb_sel1 = 2'b10;
        for (int j = 0; j < 9; j++) begin
            exp_q.push_back(j == 8 ? RDYV : SETV); tick();
            if (got !== expv) begin failures++; $display("FAIL rst_settle[%0d]: got %b want %b", j, got, expv); end
        end
        exp_q.push_back(7'b110_10_10); tick();
        if (got !== expv) begin failures++; $display("FAIL rst_pre: got %b want %b", got, expv); end
        rst = 1'b1; en = 1'b0;
        exp_q.push_back(OFFV); tick();
        if (got !== expv) begin failures++; $display("FAIL rst_mid: got %b want %b", got, expv); end
        rst = 1'b0; en = 1'b1; atb_req = 2'b01; atb_sel0 = 2'b11;
        for (int j = 0; j < 9; j++) begin
            exp_q.push_back(j == 8 ? RDYV : SETV); tick();
            if (got !== expv) begin failures++; $display("FAIL rst_resettle[%0d]: got %b want %b", j, got, expv); end
        end
        exp_q.push_back(7'b110_01_11); tick();
        if (got !== expv) begin failures++; $display("FAIL grant0_only: got %b want %b", got, expv); end
        rst = 1'b1; en = 1'b0; atb_req = 2'b11;
        exp_q.push_back(OFFV); tick();
        if (got !== expv) begin failures++; $display("FAIL rst_mid2: got %b want %b", got, expv); end
        rst = 1'b0; en = 1'b1; atb_sel0 = 2'b01; atb_sel1 = 2'b10;
        for (int j = 0; j < 9; j++) begin
            exp_q.push_back(j == 8 ? RDYV : SETV); tick();
            if (got !== expv) begin failures++; $display("FAIL rst_settle2[%0d]: got %b want %b", j, got, expv); end
        end
        exp_q.push_back(7'b110_01_01); tick();
        if (got !== expv) begin failures++; $display("FAIL tie_after_reset: got %b want %b", got, expv); end
    endtask

    initial begin
        #1;
        test_reset();
        test_powerup();
        test_fault_ready();
        test_abort();
        test_simultaneous();
        test_gating();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/local_bias_ctrl.md
# local_bias_ctrl

Digital controller for the `local_bias` analog block. Sequences power-up and power-down through `pdb` with a programmable settle interval, and drops bias on a supply-window fault. Shares the block's 2-bit analog test bus selector `atb_ena` between two requesters using round-robin arbitration with break-before-make switching. Sits in the digital control domain, with its outputs wired straight to `local_bias` pins.

## Interface
- `SETTLE_CYCLES`, default 64: cycles `pdb` stays high before `bias_ready` asserts; legal range 1 to 65535.
- `clk` in 1: the single clock; all logic is on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `en` in 1: bias enable request (level).
- `sup_ok` in 1: supply-window good. High when vddana_1p8, vddana_0p8 and vssana are all within window; driven by external comparators, already synchronised to `clk`.
- `atb_req` in 2: bit i is the test-bus request from requester i (level, held while in use).
- `atb_sel0` in 2: test-bus code wanted by requester 0.
- `atb_sel1` in 2: test-bus code wanted by requester 1.
- `pdb` out 1: power-down-bar to `local_bias`; 1 means bias on.
- `bias_ready` out 1: bias has settled.
- `atb_ena` out 2: test-bus selector to `local_bias`.
- `atb_gnt` out 2: one-hot-or-zero grant to the requesters.
- `fault` out 1: supply fault seen; sticky.

## Operation
- All outputs are registered.
- Reset values: state OFF, `pdb`=0, `bias_ready`=0, `atb_ena`=00, `atb_gnt`=00, `fault`=0, settle counter 0, round-robin pointer favours requester 0.
- The FSM has four states: OFF, SETTLE, READY and FAULT.
- **OFF**
  - Outputs: `pdb`=0.
  - If `en` and `sup_ok`, go to SETTLE and load the counter with `SETTLE_CYCLES`-1.
  - If `en` and not `sup_ok`, stay in OFF; `fault` is not set.
- **SETTLE**
  - Outputs: `pdb`=1.
  - Counter decrements each cycle. Counter width is $clog2(`SETTLE_CYCLES`+1) bits, with no wrap.
  - Transitions, in priority order:
    - not `sup_ok`: go to FAULT.
    - not `en`: go to OFF.
    - counter == 0: go to READY.
- **READY**
  - Outputs: `pdb`=1, `bias_ready`=1.
  - Transitions, in priority order:
    - not `sup_ok`: go to FAULT.
    - not `en`: go to OFF.
- **FAULT**
  - Outputs: `pdb`=0, `fault`=1.
  - Leave only when `en`=0, going to OFF; `fault` clears on that transition.
  - Stays in FAULT while `en`=1, regardless of `sup_ok`.
- **Arbiter: when it runs**
  - Active only in READY. In any other state, `atb_gnt`=00 and `atb_ena`=00.
- **Arbiter: issuing a grant**
  - Grant only when the arbiter is idle, i.e. `atb_gnt`=00 in the current cycle and no gap cycle is pending.
  - Single request: grant that requester.
  - Both requesting: grant the requester the pointer favours.
  - After any grant, the pointer moves to favour the other requester.
  - On grant, `atb_ena` latches the granted requester's `atb_sel`. Later `atb_sel` changes are ignored until the next grant.
- **Arbiter: holding and releasing**
  - A grant is held while its `atb_req` bit stays 1; no preemption.
  - When the request drops, `atb_gnt` and `atb_ena` go to 00.
  - The arbiter then takes one mandatory gap cycle with no grant before any new grant (break-before-make on the analog bus).
- **Leaving READY:** `atb_gnt`/`atb_ena` clear on the same edge as the state change; the pointer is kept.

## Timing
- Power-up: `en`=1 and `sup_ok`=1 sampled at edge k.
  - `pdb`=1 from edge k.
  - `bias_ready`=1 from edge k+`SETTLE_CYCLES`.
- `en` low sampled at edge k in SETTLE or READY: `pdb`, `bias_ready`, `atb_gnt` and `atb_ena` are all 0 from edge k.
- `sup_ok` low sampled at edge k: `pdb`=0 and `fault`=1 from edge k. If `en` also drops in the same cycle, FAULT still wins.
- Grant: request sampled at edge k while READY and idle gives `atb_gnt`/`atb_ena` valid from edge k.
  - A request seen at the same edge READY is entered is first eligible at edge k+1.
- Release: `atb_req` bit low at edge k.
  - Grant and bus are 00 from edge k.
  - Edge k+1 is the gap cycle.
  - The earliest next grant is at edge k+2.
- `atb_gnt` bits are never both 1. `atb_ena` is nonzero only while `atb_gnt` is nonzero.
- `rst` high at any edge forces all reset values at that edge, including mid-settle and mid-grant.

## Test plan
- **Power-up:** `SETTLE_CYCLES`=8, `sup_ok`=1, `en` rises at edge 10 → `pdb`=1 at edge 10, `bias_ready`=1 at edge 18, `fault`=0 throughout.
- **Fault while READY:** in READY, `sup_ok`=0 for one cycle → `pdb`=0 and `fault`=1 next edge. Both stay so after `sup_ok` returns to 1. With `en`=0, the FSM goes to OFF and `fault` clears. With `en`=1 again, a new settle of 8 cycles runs.
- **Abort mid-settle:** `en` drops after 3 settle cycles → `pdb`=0, `bias_ready` never asserts. Re-raising `en` restarts the full 8-cycle count.
- **Simultaneous requests:** both requests high with `atb_sel0`=01 and `atb_sel1`=10 (requester 0 favoured after reset) → `atb_gnt`=01, `atb_ena`=01. Drop `atb_req[0]` at edge k → 00 at k, gap at k+1, then `atb_gnt`=10 and `atb_ena`=10 at k+2.
- **Latching and gating:**
  - Changing `atb_sel1` to 11 while granted leaves `atb_ena` at 10.
  - Requests while in OFF or SETTLE produce `atb_gnt`=00.
  - A `sup_ok` drop during a grant clears `atb_gnt`/`atb_ena` on the same edge that `pdb` goes 0.
- **Reset mid-operation:** `rst`=1 for one cycle while READY with requester 1 granted → all outputs at reset values next edge. Requester 0 wins the first tie after re-power-up.
